cla_word_sequencer: RTL and testbench

Upstream/downstream controller for the registered 4-bit carry-lookahead adder stage (`toplevel`). The block accepts wide operands over a valid/ready handshake and feeds the adder one nibble per cycle, least significant nibble first. Each nibble's carry-out is routed back into the next nibble's carry-in. The block collects the registered nibble sums into a full-width result with carry-out and presents it on an output valid/ready handshake.

---
 rtl/cla_word_sequencer.sv | 116 +++++++++++
 tb/tb_cla_word_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cla_word_sequencer.sv
// Sequences a wide add through a registered 4-bit carry-lookahead stage, one nibble
// per cycle (LSB first), chaining the stage's carry-out back into its carry-in.
module cla_word_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   c_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   c_out,
  output logic [3:0]             add_x,
  output logic [3:0]             add_y,
  output logic                   add_cin,
  input  logic [3:0]             add_z,
  input  logic                   add_cout
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             cin_q, cin_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    add_x   = 4'h0;
    add_y   = 4'h0;
    add_cin = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          cin_d   = c_in;
          sum_d   = '0;
          cout_d  = 1'b0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Cycle k feeds nibble k and retires nibble k-1 from the stage's register.
        for (int k = 0; k < NIBBLES; k++) begin
          if (idx_q == IDX_W'(k)) begin
            add_x = a_q[4*k +: 4];
            add_y = b_q[4*k +: 4];
          end
          if (idx_q == IDX_W'(k + 1)) begin
            sum_d[4*k +: 4] = add_z;
          end
        end
        if (idx_q == '0)
          add_cin = cin_q;
        else if (idx_q != LAST_IDX)
          add_cin = add_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = add_cout;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign c_out     = cout_q;

endmodule

// File: tb/tb_cla_word_sequencer.sv
// Bench for cla_word_sequencer with a behavioural registered 4-bit adder stage.
module tb_cla_word_sequencer;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         res;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic [3:0]   add_x;
  logic [3:0]   add_y;
  logic         add_cin;
  logic [3:0]   add_z;
  logic         add_cout;

  int checks = 0;
  int errors = 0;

  cla_word_sequencer #(.NIBBLES(N)) dut (
    .clk(clk), .res(res),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out),
    .add_x(add_x), .add_y(add_y), .add_cin(add_cin),
    .add_z(add_z), .add_cout(add_cout)
  );

  always #5 clk = ~clk;

  // Registered adder stage: one-cycle latency, shares clk/res.
  always @(posedge clk or posedge res) begin
    if (res) begin
      add_z    <= 4'h0;
      add_cout <= 1'b0;
    end else begin
      {add_cout, add_z} <= {1'b0, add_x} + {1'b0, add_y} + {4'h0, add_cin};
    end
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
    logic [3:0]   cmask;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Accepts one operation and stops at the first DONE sample point.
  task automatic run_op(input string nm, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vc, input logic [W-1:0] es, input logic eco,
                        input logic [3:0] emask);
    int lat;
    logic [3:0] cmask;
    logic xy_ok;
    check({nm, " in_ready before accept"}, in_ready, 1'b1);
    a = va; b = vb; c_in = vc; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = '0; b = '0; c_in = 1'b0;
    lat = 0; cmask = 4'h0; xy_ok = 1'b1;
    while (!out_valid && lat < 20) begin
      if (lat < N) begin
        cmask[lat] = add_cin;
        if (add_x !== va[4*lat +: 4] || add_y !== vb[4*lat +: 4]) xy_ok = 1'b0;
      end else if (lat == N) begin
        if (add_x !== 4'h0 || add_y !== 4'h0 || add_cin !== 1'b0) xy_ok = 1'b0;
      end
      if (in_ready !== 1'b0) xy_ok = 1'b0;
      step();
      lat++;
    end
    check({nm, " latency"}, lat, N + 1);
    check({nm, " add_x/add_y per nibble"}, xy_ok, 1'b1);
    check({nm, " add_cin chain"}, cmask, emask);
    check({nm, " sum"}, sum, es);
    check({nm, " c_out"}, c_out, eco);
  endtask

  initial begin
    vecs[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'b0000};
    vecs[1] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 4'b0110};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 4'b1111};
    vecs[3] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 4'b0000};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 4'b0000};
    vecs[5] = '{16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 4'b1111};
    vecs[6] = '{16'hABCD, 16'h5432, 1'b1, 16'h0000, 1'b1, 4'b1111};

    res = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; out_ready = 1'b1;
    #2;
    check("reset in_ready", in_ready, 1'b1);
    check("reset out_valid", out_valid, 1'b0);
    check("reset sum", sum, 16'h0000);
    check("reset c_out", c_out, 1'b0);
    check("reset add_x/y/cin", {add_x, add_y, add_cin}, 9'h000);
    step();
    res = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
             vecs[i].s, vecs[i].co, vecs[i].cmask);
      out_ready = 1'b1;
      step();
      check($sformatf("vec%0d back to idle", i), {in_ready, out_valid}, 2'b10);
    end

    // Backpressure: hold result for 3 cycles while a new offer is pending.
    out_ready = 1'b0;
    run_op("bp", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 4'b0000);
    a = 16'h1111; b = 16'h1111; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp wait%0d hold", i), {out_valid, in_ready, c_out, sum}, {3'b100, 16'h5555});
      step();
    end
    check("bp still done", out_valid, 1'b1);
    out_ready = 1'b1;
    step();
    check("bp handshake to idle", {in_ready, out_valid}, 2'b10);
    check("bp sum kept after handshake", sum, 16'h5555);
    in_valid = 1'b0;
    step();
    check("bp no accept in done", in_ready, 1'b1);

    // Asynchronous reset in the middle of RUN.
    a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("mid-run idx2 nibble", {add_x, add_y}, 8'hFF);
    check("mid-run partial sum", sum, 16'h000E);
    #2;
    res = 1'b1;
    #1;
    check("async reset ready/valid", {in_ready, out_valid}, 2'b10);
    check("async reset sum/c_out", {c_out, sum}, 17'h0);
    check("async reset add ports", {add_x, add_y, add_cin}, 9'h000);
    step();
    res = 1'b0;
    step();
    run_op("post-reset", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 4'b0000);
    step();

    // Back-to-back with in_valid held high.
    begin
      logic [W-1:0] oa[3], ob[3], os[3];
      logic         oc[3];
      int acc[3];
      int na, nr, cyc;
      logic pre;
      oa = '{16'h1111, 16'hF000, 16'h7FFF};
      ob = '{16'h2222, 16'h1000, 16'h0001};
      os = '{16'h3333, 16'h0000, 16'h8000};
      oc = '{1'b0, 1'b1, 1'b0};
      na = 0; nr = 0; cyc = 0;
      out_ready = 1'b1; c_in = 1'b0;
      a = oa[0]; b = ob[0]; in_valid = 1'b1;
      acc = '{0, 0, 0};
      while (nr < 3 && cyc < 100) begin
        pre = in_ready && in_valid;
        step();
        cyc++;
        if (pre) begin
          acc[na] = cyc;
          na++;
          if (na < 3) begin
            a = oa[na]; b = ob[na];
          end else begin
            in_valid = 1'b0;
          end
        end
        if (out_valid) begin
          check($sformatf("b2b op%0d result", nr), {c_out, sum}, {oc[nr], os[nr]});
          nr++;
        end
      end
      check("b2b all results", nr, 3);
      check("b2b interval 0-1", acc[1] - acc[0], N + 3);
      check("b2b interval 1-2", acc[2] - acc[1], N + 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
